ucode_sequencer: RTL and testbench
==================================

Name: ucode_sequencer

Overview:
- Initiator side of the register file's microcode/ghost-register interface.
- On a trigger from decode, it stalls the main pipeline and drives ucode_flag.
- It then issues a micro-op routine from an internal programmable store and returns the register file to regular mode when the routine completes.
- Micro-op operand fields may be literal register indices or substitutions of the triggering instruction's rd/rs1/rs2.

Parameters:
- STRIDE, 8: micro-op words per routine; routine for opcode n starts at n*STRIDE.
- DEPTH, 128: micro-op store words (16*STRIDE); address width = clog2(DEPTH).
- WARMUP, 2: cycles ucode_flag is held high before the first issue (register file copies main->ghost on the second edge after the flag rises).
- DRAIN, 3: cycles ucode_flag stays high after the last micro-op is accepted, so in-flight writes land in the ghost file.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- trig_valid  in  1  decode requests a microcoded instruction
- trig_ready  out  1  high only in IDLE with abort low
- trig_opcode  in  4  routine select
- trig_rd, trig_rs1, trig_rs2  in  4 each  architectural operands of the trigger
- abort  in  1  flush; kills the routine
- prog_we  in  1  store write enable (honoured only in IDLE)
- prog_addr  in  clog2(DEPTH)  store address
- prog_data  in  32  store word
- ucode_flag  out  1  to register file ucode_flag
- stall  out  1  freeze fetch/decode; high in every state except IDLE
- uop_valid  out  1  micro-op valid
- uop_ready  in  1  pipeline accepts the micro-op
- uop_op  out  4  micro-op opcode
- uop_rd, uop_rs1, uop_rs2  out  4 each  resolved register indices
- uop_imm  out  12  immediate
- done  out  1  one-cycle pulse on normal completion
- overrun  out  1  one-cycle pulse with done when a routine hits STRIDE words without a last bit

Behaviour:
- Store word layout:
  - [31] last
  - [30:27] op
  - [26:22] rd_sel
  - [21:17] rs1_sel
  - [16:12] rs2_sel
  - [11:0] imm
- Operand select (5-bit sel):
  - bit4=0: literal index sel[3:0].
  - bit4=1: sel[1:0] chooses 0=trig_rd, 1=trig_rs1, 2=trig_rs2, 3=r15.
  - Trigger operands are latched at acceptance and are not sampled again.
- Store contents:
  - Synchronous write; not cleared by reset.
  - Contents are undefined until programmed.
  - prog_we outside IDLE is ignored (no write).
- Reset: state IDLE; ucode_flag, stall, uop_valid, done and overrun are 0; all uop_* fields are 0; counters are 0.
- FSM transitions:
  - IDLE: trig_valid & trig_ready -> WARMUP. Latch operands; addr = trig_opcode*STRIDE; offset = 0; ucode_flag and stall go 1 at the next edge.
  - WARMUP: count WARMUP cycles -> ISSUE. uop_valid stays 0 throughout.
  - ISSUE: uop_* is registered from the store word at addr. uop_valid first asserts on the cycle after WARMUP ends.
    - uop_* is held stable while uop_valid & !uop_ready.
    - On acceptance of a word with last=1, or at offset == STRIDE-1 (overrun): -> DRAIN.
    - Otherwise addr+1, offset+1, and the next word is presented with no bubble (back-to-back acceptance allowed).
  - DRAIN: uop_valid=0; ucode_flag=1 for DRAIN cycles -> DONE.
  - DONE: one cycle with ucode_flag=0, stall=1, done=1 (overrun=1 if applicable) -> IDLE.
- Trigger during busy: not accepted; trig_ready=0; the request must be held by decode.
- Abort, any non-IDLE state:
  - Next edge -> IDLE, with ucode_flag, stall and uop_valid at 0.
  - No done pulse.
  - Abort has priority over acceptance in the same cycle; an accepted uop that coincides with abort is still considered consumed by the pipeline.
- Abort in IDLE: trig_ready=0 that cycle; no trigger is accepted.
- rst mid-routine: identical to the reset state next cycle; the store is preserved.
- Latency: trigger accept edge to first uop_valid is WARMUP+1 cycles.

Test Plan:
- Program opcode 2 (base 16): word16={last0, op1, rd sel 0x10, rs1 literal 3, rs2 sel 0x12, imm 5}, word17={last1, op2, rd literal 7, rs1 sel 0x11, rs2 sel 0x13, imm 0xFFF}. Trigger with rd=4, rs1=9, rs2=11 and uop_ready=1. Required: uop #1 = op1/rd4/rs1 3/rs2 11/imm5 at cycle 3 after accept; uop #2 = op2/rd7/rs1 9/rs2 15/imm FFF next cycle; ucode_flag high cycles 1..7; done at cycle 8; stall low from cycle 9.
- Same routine with uop_ready low for 4 cycles on uop #1. Required: fields stable, uop_valid held, no skipped word, done delayed by exactly 4 cycles.
- Opcode 5 store with no last bit set in words 40..47. Required: exactly 8 uops issued, then DRAIN, and done with overrun both pulsing in the same cycle.
- Abort asserted during the second ISSUE cycle. Required: next cycle IDLE, ucode_flag=0, stall=0, no done, trig_ready=1. A new trigger afterwards runs a full routine correctly.
- prog_we to addr 16 while busy with new data. Required: the write is ignored, and a rerun of opcode 2 issues the original word.
- rst asserted in DRAIN. Required: all outputs 0 next cycle; a subsequent trigger replays the programmed routine unchanged.

Source files
------------

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: on a decode trigger it stalls the pipeline, raises ucode_flag and
// issues a routine of micro-ops from a programmable store, then returns to regular mode.
module ucode_sequencer #(
    parameter int unsigned STRIDE = 8,
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned WARMUP = 2,
    parameter int unsigned DRAIN  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trig_valid,
    output logic                     trig_ready,
    input  logic [3:0]               trig_opcode,
    input  logic [3:0]               trig_rd,
    input  logic [3:0]               trig_rs1,
    input  logic [3:0]               trig_rs2,
    input  logic                     abort,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic                     ucode_flag,
    output logic                     stall,
    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic [3:0]               uop_op,
    output logic [3:0]               uop_rd,
    output logic [3:0]               uop_rs1,
    output logic [3:0]               uop_rs2,
    output logic [11:0]              uop_imm,
    output logic                     done,
    output logic                     overrun
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned OW     = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned MaxCnt = (WARMUP > DRAIN) ? WARMUP : DRAIN;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);

    typedef enum logic [2:0] {StIdle, StWarmup, StIssue, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d, rd_addr;
    logic [OW-1:0]     off_q, off_d;
    logic              ovr_q, ovr_d;
    logic [3:0]        t_rd_q, t_rd_d, t_rs1_q, t_rs1_d, t_rs2_q, t_rs2_d;
    logic              load_uop;
    logic              last_q;
    logic [3:0]        op_q, rd_q, rs1_q, rs2_q;
    logic [11:0]       imm_q;
    logic [31:0]       word;
    logic [31:0]       mem [DEPTH];

    function automatic logic [3:0] resolve(input logic [4:0] sel, input logic [3:0] rd,
                                           input logic [3:0] rs1, input logic [3:0] rs2);
        if (!sel[4]) return sel[3:0];
        case (sel[1:0])
            2'd0:    return rd;
            2'd1:    return rs1;
            2'd2:    return rs2;
            default: return 4'd15;
        endcase
    endfunction

    assign trig_ready = (state_q == StIdle) && !abort;
    assign word       = mem[rd_addr];

    // Store is not reset so a routine survives rst; writes only land while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state_q == StIdle) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        off_d    = off_q;
        ovr_d    = ovr_q;
        t_rd_d   = t_rd_q;
        t_rs1_d  = t_rs1_q;
        t_rs2_d  = t_rs2_q;
        load_uop = 1'b0;
        rd_addr  = addr_q;
        case (state_q)
            StIdle: begin
                if (trig_valid && trig_ready) begin
                    state_d = StWarmup;
                    cnt_d   = '0;
                    addr_d  = AW'(32'(trig_opcode) * STRIDE);
                    off_d   = '0;
                    ovr_d   = 1'b0;
                    t_rd_d  = trig_rd;
                    t_rs1_d = trig_rs1;
                    t_rs2_d = trig_rs2;
                end
            end
            StWarmup: begin
                if (cnt_q == CntW'(WARMUP - 1)) begin
                    state_d  = StIssue;
                    load_uop = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIssue: begin
                if (uop_ready) begin
                    if (last_q || off_q == OW'(STRIDE - 1)) begin
                        state_d = StDrain;
                        cnt_d   = '0;
                        ovr_d   = !last_q;
                    end else begin
                        // Prefetch the next word so acceptance can be back-to-back.
                        addr_d   = addr_q + AW'(1);
                        off_d    = off_q + OW'(1);
                        rd_addr  = addr_q + AW'(1);
                        load_uop = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == CntW'(DRAIN - 1)) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort && state_q != StIdle) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            ovr_q   <= 1'b0;
            t_rd_q  <= '0;
            t_rs1_q <= '0;
            t_rs2_q <= '0;
            last_q  <= 1'b0;
            op_q    <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            ovr_q   <= ovr_d;
            t_rd_q  <= t_rd_d;
            t_rs1_q <= t_rs1_d;
            t_rs2_q <= t_rs2_d;
            if (load_uop) begin
                last_q <= word[31];
                op_q   <= word[30:27];
                rd_q   <= resolve(word[26:22], t_rd_q, t_rs1_q, t_rs2_q);
                rs1_q  <= resolve(word[21:17], t_rd_q, t_rs1_q, t_rs2_q);
                rs2_q  <= resolve(word[16:12], t_rd_q, t_rs1_q, t_rs2_q);
                imm_q  <= word[11:0];
            end
        end
    end

    assign ucode_flag = (state_q == StWarmup) || (state_q == StIssue) || (state_q == StDrain);
    assign stall      = (state_q != StIdle);
    assign uop_valid  = (state_q == StIssue);
    assign done       = (state_q == StDone);
    assign overrun    = (state_q == StDone) && ovr_q;
    assign uop_op     = op_q;
    assign uop_rd     = rd_q;
    assign uop_rs1    = rs1_q;
    assign uop_rs2    = rs2_q;
    assign uop_imm    = imm_q;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Scoreboard bench for ucode_sequencer: stimulus queues expected micro-ops and done pulses,
// a negedge monitor compares them against what the sequencer presents.
module tb_ucode_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trig_valid = 1'b0;
    logic        trig_ready;
    logic [3:0]  trig_opcode = '0, trig_rd = '0, trig_rs1 = '0, trig_rs2 = '0;
    logic        abort = 1'b0;
    logic        prog_we = 1'b0;
    logic [6:0]  prog_addr = '0;
    logic [31:0] prog_data = '0;
    logic        ucode_flag, stall, uop_valid;
    logic        uop_ready = 1'b1;
    logic [3:0]  uop_op, uop_rd, uop_rs1, uop_rs2;
    logic [11:0] uop_imm;
    logic        done, overrun;

    typedef struct {
        logic [3:0]  op, rd, rs1, rs2;
        logic [11:0] imm;
        int          cyc;
    } uop_t;

    typedef struct {
        int cyc;
        bit ovr;
    } done_t;

    uop_t  uq[$];
    done_t dq[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    ucode_sequencer dut (
        .clk(clk), .rst(rst),
        .trig_valid(trig_valid), .trig_ready(trig_ready), .trig_opcode(trig_opcode),
        .trig_rd(trig_rd), .trig_rs1(trig_rs1), .trig_rs2(trig_rs2),
        .abort(abort), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .ucode_flag(ucode_flag), .stall(stall), .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_op(uop_op), .uop_rd(uop_rd), .uop_rs1(uop_rs1), .uop_rs2(uop_rs2),
        .uop_imm(uop_imm), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mkword(input logic last, input logic [3:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [11:0] imm);
        return {last, op, rd, rs1, rs2, imm};
    endfunction

    task automatic prog(input logic [6:0] a, input logic [31:0] d);
        step();
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
    endtask

    task automatic push_uop(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                            input logic [3:0] rs2, input logic [11:0] imm, input int at);
        uop_t e;
        e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.cyc = at;
        uq.push_back(e);
    endtask

    task automatic push_done(input int at, input bit ovr);
        done_t e;
        e.cyc = at; e.ovr = ovr;
        dq.push_back(e);
    endtask

    // Returns in the cycle after acceptance; c is the accept cycle.
    task automatic trigger(input logic [3:0] opc, input logic [3:0] rd, input logic [3:0] rs1,
                           input logic [3:0] rs2, output int c);
        step();
        trig_valid = 1'b1; trig_opcode = opc; trig_rd = rd; trig_rs1 = rs1; trig_rs2 = rs2;
        c = cyc;
        @(negedge clk);
        chk("trig_ready_idle", 32'(trig_ready), 1);
        step();
        trig_valid = 1'b0;
        trig_rd = 4'hE; trig_rs1 = 4'hE; trig_rs2 = 4'hE;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) step();
    endtask

    // Monitor: peeks the expected micro-op every valid cycle, pops on acceptance.
    always @(negedge clk) begin
        uop_t  u;
        done_t d;
        if (uop_valid === 1'b1) begin
            chk("uop_expected", 32'(uq.size() != 0), 1);
            if (uq.size() != 0) begin
                chk("uop_op", 32'(uop_op), 32'(uq[0].op));
                chk("uop_rd", 32'(uop_rd), 32'(uq[0].rd));
                chk("uop_rs1", 32'(uop_rs1), 32'(uq[0].rs1));
                chk("uop_rs2", 32'(uop_rs2), 32'(uq[0].rs2));
                chk("uop_imm", 32'(uop_imm), 32'(uq[0].imm));
                if (uop_ready) begin
                    u = uq.pop_front();
                    chk("uop_accept_cycle", cyc, u.cyc);
                end
            end
        end
        if (done === 1'b1) begin
            chk("done_expected", 32'(dq.size() != 0), 1);
            if (dq.size() != 0) begin
                d = dq.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_overrun", 32'(overrun), 32'(d.ovr));
            end
        end else if (overrun === 1'b1) begin
            chk("overrun_without_done", 32'(overrun), 0);
        end
    end

    initial begin
        int c;
        wait_cycles(3);
        @(negedge clk);
        chk("rst_flag", 32'(ucode_flag), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_valid", 32'(uop_valid), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_fields", {uop_op, uop_rd, uop_rs1, uop_rs2, uop_imm}, 0);
        chk("rst_trig_ready", 32'(trig_ready), 1);
        step();
        rst = 1'b0;

        prog(7'd16, mkword(1'b0, 4'h1, 5'h10, 5'h03, 5'h12, 12'h005));
        prog(7'd17, mkword(1'b1, 4'h2, 5'h07, 5'h11, 5'h13, 12'hFFF));
        for (int k = 0; k < 8; k++) begin
            prog(7'(40 + k), mkword(1'b0, 4'(k), 5'(k), 5'h11, 5'h13, 12'(256 + k)));
        end
        step();
        prog_we = 1'b0;

        // Basic routine, full timeline of flag and stall.
        trigger(4'd2, 4'd4, 4'd9, 4'd11, c);
        push_uop(4'h1, 4'd4, 4'd3, 4'd11, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd9, 4'd15, 12'hFFF, c + 4);
        push_done(c + 8, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("timeline_flag", 32'(ucode_flag), 32'(k <= 7));
            chk("timeline_stall", 32'(stall), 32'(k <= 8));
            step();
        end

        // Back-pressure on the first micro-op for four cycles.
        uop_ready = 1'b0;
        trigger(4'd2, 4'd4, 4'd9, 4'd11, c);
        push_uop(4'h1, 4'd4, 4'd3, 4'd11, 12'h005, c + 7);
        push_uop(4'h2, 4'd7, 4'd9, 4'd15, 12'hFFF, c + 8);
        push_done(c + 12, 1'b0);
        for (int k = 1; k < 7; k++) begin
            @(negedge clk);
            if (k >= 3) chk("stall_valid_held", 32'(uop_valid), 1);
            step();
        end
        uop_ready = 1'b1;
        wait_cycles(7);

        // Overrun: eight words, none marked last.
        trigger(4'd5, 4'd1, 4'd2, 4'd3, c);
        for (int k = 0; k < 8; k++) begin
            push_uop(4'(k), 4'(k), 4'd2, 4'd15, 12'(256 + k), c + 3 + k);
        end
        push_done(c + 14, 1'b1);
        wait_cycles(15);

        // Abort on the second issue cycle; that micro-op is still consumed.
        trigger(4'd2, 4'd4, 4'd9, 4'd11, c);
        push_uop(4'h1, 4'd4, 4'd3, 4'd11, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd9, 4'd15, 12'hFFF, c + 4);
        wait_cycles(3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_flag", 32'(ucode_flag), 0);
        chk("abort_stall", 32'(stall), 0);
        chk("abort_valid", 32'(uop_valid), 0);
        chk("abort_trig_ready", 32'(trig_ready), 1);
        wait_cycles(10);

        // Abort while idle blocks acceptance.
        step();
        abort = 1'b1; trig_valid = 1'b1; trig_opcode = 4'd2;
        @(negedge clk);
        chk("idle_abort_ready", 32'(trig_ready), 0);
        step();
        abort = 1'b0; trig_valid = 1'b0;
        @(negedge clk);
        chk("idle_abort_no_accept", 32'(stall), 0);

        // Fresh routine after abort, different operands.
        trigger(4'd2, 4'd5, 4'd6, 4'd8, c);
        push_uop(4'h1, 4'd5, 4'd3, 4'd8, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd6, 4'd15, 12'hFFF, c + 4);
        push_done(c + 8, 1'b0);
        wait_cycles(10);

        // Store write while busy must be dropped.
        trigger(4'd2, 4'd4, 4'd9, 4'd11, c);
        push_uop(4'h1, 4'd4, 4'd3, 4'd11, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd9, 4'd15, 12'hFFF, c + 4);
        push_done(c + 8, 1'b0);
        prog_we = 1'b1; prog_addr = 7'd16;
        prog_data = mkword(1'b1, 4'hA, 5'h01, 5'h02, 5'h03, 12'h0AA);
        step();
        prog_we = 1'b0;
        wait_cycles(9);
        trigger(4'd2, 4'd4, 4'd9, 4'd11, c);
        push_uop(4'h1, 4'd4, 4'd3, 4'd11, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd9, 4'd15, 12'hFFF, c + 4);
        push_done(c + 8, 1'b0);
        wait_cycles(10);

        // Reset during drain, then replay from the preserved store.
        trigger(4'd2, 4'd4, 4'd9, 4'd11, c);
        push_uop(4'h1, 4'd4, 4'd3, 4'd11, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd9, 4'd15, 12'hFFF, c + 4);
        wait_cycles(5);
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("midrst_flag", 32'(ucode_flag), 0);
        chk("midrst_stall", 32'(stall), 0);
        chk("midrst_valid", 32'(uop_valid), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_fields", {uop_op, uop_rd, uop_rs1, uop_rs2, uop_imm}, 0);
        rst = 1'b0;
        trigger(4'd2, 4'd3, 4'd1, 4'd2, c);
        push_uop(4'h1, 4'd3, 4'd3, 4'd2, 12'h005, c + 3);
        push_uop(4'h2, 4'd7, 4'd1, 4'd15, 12'hFFF, c + 4);
        push_done(c + 8, 1'b0);
        wait_cycles(12);

        @(negedge clk);
        chk("uop_queue_drained", 32'(uq.size()), 0);
        chk("done_queue_drained", 32'(dq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
